rr_arbiter8: RTL and testbench

- Round-robin arbiter sharing one resource among 8 requesters, e.g. a shared seven-segment display or a single bus port in the npc lab tree.
- Registered one-hot grant plus 3-bit grant index.
- Per-grant hold timeout, so one requester cannot starve the others.
- Drives an active-low seven-segment digit with the current grant index; blank when no grant is held.

---
 rtl/rr_arbiter8_pkg.sv | 23 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_arbiter8.sv | 121 ++++++++++++
 tb/tb_rr_arbiter8.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding,
// index width and active-low seven-segment patterns {g,f,e,d,c,b,a}.
package rr_arbiter8_pkg;

  localparam int N   = 8;
  localparam int IDW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: rotate req so index last+1 sits at bit 0,
// take the lowest set bit, then add the rotation back.
module rr_pick
  import rr_arbiter8_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] win,
  output logic           any
);

  logic [IDW-1:0] start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW-1:0] pos;

  assign start = last + 3'd1;
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[N-1:0];

  // NOTE: pos gets a default before the loop so this stays purely
  // combinational; walking downward lets the lowest set index win.
  always_comb begin
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IDW'(i);
    end
  end

  assign win = pos + start;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with per-grant hold timeout, registered
// one-hot grant, grant index and seven-segment display of the owner.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [7:0]   req,
  input  logic         done,
  output logic [7:0]   gnt,
  output logic [2:0]   gnt_id,
  output logic         gnt_valid,
  output logic         timeout,
  output logic [6:0]   hex
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [6:0]     hex_q, hex_d;
  logic           timeout_q, timeout_d;

  logic [N-1:0]   pick_req;
  logic [IDW-1:0] pick_win;
  logic           pick_any;
  logic [6:0]     win_seg;
  logic           hold_limit;
  logic           release_now;

  // The current owner is masked out so a release always hands off to someone else.
  assign pick_req = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;

  rr_pick u_pick (
    .req  (pick_req),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  always_comb begin
    win_seg = SEG_BLANK;
    case (pick_win)
      3'd0: win_seg = SEG_0;
      3'd1: win_seg = SEG_1;
      3'd2: win_seg = SEG_2;
      3'd3: win_seg = SEG_3;
      3'd4: win_seg = SEG_4;
      3'd5: win_seg = SEG_5;
      3'd6: win_seg = SEG_6;
      3'd7: win_seg = SEG_7;
      default: win_seg = SEG_BLANK;
    endcase
  end

  assign hold_limit  = (state_q == ST_GRANT) && (hold_q == HOLD_LAST);
  assign release_now = !req[gnt_id_q] || done || hold_limit || !en;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    hex_d     = hex_q;
    timeout_d = hold_limit;

    if (state_q == ST_GRANT && !release_now) begin
      hold_d = hold_q + 1'b1;
    end else if (en && pick_any) begin
      // New grant, either from idle or as a gap-free handoff.
      state_d  = ST_GRANT;
      last_d   = pick_win;
      hold_d   = '0;
      gnt_d    = 8'b1 << pick_win;
      gnt_id_d = pick_win;
      hex_d    = win_seg;
    end else begin
      state_d  = ST_IDLE;
      hold_d   = '0;
      gnt_d    = '0;
      gnt_id_d = '0;
      hex_d    = SEG_BLANK;
    end
  end

  // NOTE: registers use non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 3'd7;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      hex_q     <= SEG_BLANK;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      hex_q     <= hex_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;
  assign hex       = hex_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: one instance at MAX_HOLD=16, one at
// MAX_HOLD=4 for the timeout scenario; both share the same stimulus.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [7:0] req;

  logic [7:0] a_gnt, b_gnt;
  logic [2:0] a_id, b_id;
  logic       a_v, b_v, a_to, b_to;
  logic [6:0] a_hex, b_hex;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(a_gnt), .gnt_id(a_id), .gnt_valid(a_v), .timeout(a_to), .hex(a_hex)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(b_gnt), .gnt_id(b_id), .gnt_valid(b_v), .timeout(b_to), .hex(b_hex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] seg(input int id);
    case (id)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] o_gnt, input logic [2:0] o_id,
                     input logic o_v, input logic o_to, input logic [6:0] o_hex,
                     input int e_id, input logic e_v, input logic e_to);
    logic [7:0] e_gnt;
    e_gnt = 8'b1 << e_id;
    if (e_v) begin
      check({tag, "_gnt"}, 32'(o_gnt), 32'(e_gnt));
      check({tag, "_id"},  32'(o_id),  32'(e_id));
      check({tag, "_hex"}, 32'(o_hex), 32'(seg(e_id)));
    end else begin
      check({tag, "_gnt"}, 32'(o_gnt), 32'h0);
      check({tag, "_hex"}, 32'(o_hex), 32'h7F);
    end
    check({tag, "_valid"},   32'(o_v),  32'(e_v));
    check({tag, "_timeout"}, 32'(o_to), 32'(e_to));
  endtask

  task automatic chka(input string tag, input int e_id, input logic e_v, input logic e_to);
    chk(tag, a_gnt, a_id, a_v, a_to, a_hex, e_id, e_v, e_to);
  endtask

  task automatic chkb(input string tag, input int e_id, input logic e_v, input logic e_to);
    chk(tag, b_gnt, b_id, b_v, b_to, b_hex, e_id, e_v, e_to);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 8'hFF; done = 1'b0;

    // Reset has priority even with en and requests active.
    step();
    chka("reset", 0, 1'b0, 1'b0);
    check("reset_id", 32'(a_id), 32'h0);
    chkb("reset4", 0, 1'b0, 1'b0);

    // done while idle is ignored; no requests means no grant.
    rst = 1'b0; req = 8'h00; done = 1'b1;
    step();
    chka("idle_done", 0, 1'b0, 1'b0);
    done = 1'b0;

    // Single requester 2: one-cycle latency, then held.
    req = 8'h04;
    step();
    chka("t1_grant", 2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chka("t1_hold", 2, 1'b1, 1'b0);
    end
    req = 8'h00;
    step();
    chka("t1_drop", 0, 1'b0, 1'b0);

    // All requesting, done every third cycle: 0..7 then 0, 3 cycles each.
    rst = 1'b1;
    step();
    rst = 1'b0; req = 8'hFF;
    step();
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        chka("t2_rr", k, 1'b1, 1'b0);
        done = (j == 2);
        step();
      end
    end
    done = 1'b0;
    chka("t2_wrap", 0, 1'b1, 1'b0);

    // MAX_HOLD=4 with requesters 0 and 7 held: alternation by timeout.
    rst = 1'b1;
    step();
    rst = 1'b0; req = 8'h81;
    step();
    for (int j = 0; j < 4; j++) begin
      chkb("t3_own0", 0, 1'b1, 1'b0);
      step();
    end
    for (int j = 0; j < 4; j++) begin
      chkb("t3_own7", 7, 1'b1, (j == 0));
      step();
    end
    chkb("t3_back0", 0, 1'b1, 1'b1);
    step();
    chkb("t3_back0_next", 0, 1'b1, 1'b0);

    // Owner 5 drops its request while 3 waits: direct handoff.
    rst = 1'b1;
    step();
    rst = 1'b0; req = 8'h20;
    step();
    chka("t4_own5", 5, 1'b1, 1'b0);
    req = 8'h08;
    step();
    chka("t4_hand3", 3, 1'b1, 1'b0);
    req = 8'h20;
    step();
    chka("t4_hand5", 5, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chka("t4_empty", 0, 1'b0, 1'b0);

    // en low drops owner 6; afterwards 7-then-0 order picks 0 first.
    req = 8'h40;
    step();
    chka("t5_own6", 6, 1'b1, 1'b0);
    en = 1'b0;
    step();
    chka("t5_en_off", 0, 1'b0, 1'b0);
    step();
    chka("t5_en_off_stay", 0, 1'b0, 1'b0);
    en = 1'b1; req = 8'h41;
    step();
    chka("t5_pick0", 0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chka("t5_next6", 6, 1'b1, 1'b0);
    done = 1'b0;

    // Owner 4 reset mid-grant; search restarts after reset.
    req = 8'h10;
    step();
    chka("t6_own4", 4, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chka("t6_reset", 0, 1'b0, 1'b0);
    check("t6_reset_id", 32'(a_id), 32'h0);
    rst = 1'b0;
    step();
    chka("t6_regrant4", 4, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
